// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory-port arbiter
package mem_arbiter_pkg;

  localparam int ADDRESS_BITS     = 32;
  localparam int CACHE_LINE_LEN   = 128;
  localparam int BYTE_LEN         = 8;
  localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } arb_id_e;

  typedef struct packed {
    logic                      store;
    logic [ADDRESS_BITS-1:0]   addr;
    logic [CACHE_LINE_LEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and memory-side signal bundle of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_rvalid_o;
  logic [LINE_W-1:0] ic_rdata_o;

  logic              dc_req_i;
  logic              dc_store_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              dc_rvalid_o;
  logic [LINE_W-1:0] dc_rdata_o;

  logic              mem_req_o;
  logic              mem_store_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_resp_i;
  logic [LINE_W-1:0] mem_rdata_i;

  logic              busy_o;

  // slave: the arbiter itself
  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_store_i, dc_addr_i, dc_wdata_i,
    input  mem_resp_i, mem_rdata_i,
    output ic_rvalid_o, ic_rdata_o, dc_rvalid_o, dc_rdata_o,
    output mem_req_o, mem_store_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_store_i, dc_addr_i, dc_wdata_i,
    output mem_resp_i, mem_rdata_i,
    input  ic_rvalid_o, ic_rdata_o, dc_rvalid_o, dc_rdata_o,
    input  mem_req_o, mem_store_o, mem_addr_o, mem_wdata_o, busy_o
  );

endinterface

// File: rtl/mem_arbiter_picker.sv
// rtl/mem_arbiter_picker.sv - combinational grant selection (MEM_ARB_ROUND_ROBIN_EN adds alternation)
module mem_arb_picker
  import mem_arbiter_pkg::*;
(
  input  logic    ic_req_i,
  input  logic    dc_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  arb_id_e prio_i,
`endif
  output logic    grant_valid_o,
  output arb_id_e grant_o
);

  always_comb begin
    grant_valid_o = ic_req_i | dc_req_i;
    grant_o       = dc_req_i ? ARB_DC : ARB_IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // prio_i names the requester that was not granted last time
    if (ic_req_i && dc_req_i) begin
      grant_o = prio_i;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises icache/dcache line transactions onto one memory port
// Optional round-robin arbitration under MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDRESS_BITS,
  parameter int LINE_W   = CACHE_LINE_LEN,
  parameter int OFFSET_W = $clog2(LINE_W / BYTE_LEN)
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  arb_state_e        state_q, state_d;
  arb_id_e           winner_q, winner_d;
  mem_req_t          req_q, req_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              grant_valid;
  arb_id_e           grant;
  logic [ADDR_W-1:0] sel_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_id_e           prio_q, prio_d;
`endif

  mem_arb_picker u_picker (
    .ic_req_i      (bus.ic_req_i),
    .dc_req_i      (bus.dc_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .prio_i        (prio_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  assign sel_addr = (grant == ARB_DC) ? bus.dc_addr_i : bus.ic_addr_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      winner_q   <= ARB_IC;
      req_q      <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_q     <= ARB_IC;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      req_q      <= req_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_q     <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    req_d      = req_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    prio_d     = prio_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          winner_d    = grant;
          req_d.store = (grant == ARB_DC) && bus.dc_store_i;
          req_d.addr  = sel_addr & ~OFFSET_MASK;
          req_d.wdata = req_d.store ? bus.dc_wdata_i : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          prio_d      = (grant == ARB_IC) ? ARB_DC : ARB_IC;
`endif
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // responses outside WAIT are never sampled, so stray pulses are harmless
        if (bus.mem_resp_i) begin
          if (winner_q == ARB_DC) begin
            dc_rdata_d = bus.mem_rdata_i;
          end else begin
            ic_rdata_d = bus.mem_rdata_i;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req_o   = (state_q == ISSUE);
  assign bus.mem_store_o = (state_q == ISSUE) ? req_q.store : 1'b0;
  assign bus.mem_addr_o  = (state_q == ISSUE) ? req_q.addr : '0;
  assign bus.mem_wdata_o = (state_q == ISSUE) ? req_q.wdata : '0;
  assign bus.ic_rvalid_o = (state_q == RESP) && (winner_q == ARB_IC);
  assign bus.dc_rvalid_o = (state_q == RESP) && (winner_q == ARB_DC);
  assign bus.ic_rdata_o  = ic_rdata_q;
  assign bus.dc_rdata_o  = dc_rdata_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MEM_LAT = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // transaction-level model
  bit           m_active = 1'b0;
  arb_id_e      m_win    = ARB_IC;
  arb_id_e      m_prio   = ARB_IC;
  int           m_req_cyc = 0;
  int           m_rv_cyc  = -1;
  logic [31:0]  m_addr   = '0;
  bit           m_store  = 1'b0;
  logic [127:0] m_wdata  = '0;
  logic [127:0] m_ic_data = '0;
  logic [127:0] m_dc_data = '0;

  // memory model and observations
  int           resp_at_q[$];
  logic [127:0] resp_data_q[$];
  logic [31:0]  obs_addr_q[$];
  int           obs_req_cyc = -1;
  logic [31:0]  obs_addr = '0;
  bit           obs_store = 1'b0;
  logic [127:0] obs_wdata = '0;
  bit           spur = 1'b0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (spur) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = '1;
      spur = 1'b0;
    end else if (resp_at_q.size() > 0 && resp_at_q[0] == cyc) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = resp_data_q[0];
      void'(resp_at_q.pop_front());
      void'(resp_data_q.pop_front());
    end else begin
      bus.mem_resp_i  = 1'b0;
      bus.mem_rdata_i = {4{32'h5555_AAAA}};
    end
  endtask

  task automatic wait_rv(input bit is_dc, output int rv_cyc);
    rv_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (is_dc ? bus.dc_rvalid_o : bus.ic_rvalid_o) begin
        rv_cyc = cyc;
        break;
      end
    end
    if (rv_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL rvalid_timeout dc=%0d: got no rvalid within 40 cycles, required one", is_dc);
    end
  endtask

  // compare every cycle against the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    bit e_req, e_rv;
    e_req = m_active && (cyc == m_req_cyc);
    e_rv  = m_active && (cyc == m_rv_cyc);
    chk("mem_req",   bus.mem_req_o,   e_req);
    chk("mem_store", bus.mem_store_o, e_req ? m_store : 1'b0);
    chk("mem_addr",  bus.mem_addr_o,  e_req ? m_addr : 32'h0);
    chk("mem_wdata", bus.mem_wdata_o, e_req ? m_wdata : 128'h0);
    chk("ic_rvalid", bus.ic_rvalid_o, e_rv && m_win == ARB_IC);
    chk("dc_rvalid", bus.dc_rvalid_o, e_rv && m_win == ARB_DC);
    chk("ic_rdata",  bus.ic_rdata_o,  m_ic_data);
    chk("dc_rdata",  bus.dc_rdata_o,  m_dc_data);
    chk("busy",      bus.busy_o,      m_active);

    if (bus.mem_req_o === 1'b1) begin
      obs_req_cyc = cyc;
      obs_addr    = bus.mem_addr_o;
      obs_store   = bus.mem_store_o;
      obs_wdata   = bus.mem_wdata_o;
      obs_addr_q.push_back(bus.mem_addr_o);
      resp_at_q.push_back(cyc + MEM_LAT);
      resp_data_q.push_back(bus.mem_store_o ? 128'h0 : line_of(bus.mem_addr_o));
    end

    if (reset) begin
      m_active  = 1'b0;
      m_ic_data = '0;
      m_dc_data = '0;
      m_prio    = ARB_IC;
    end else if (!m_active) begin
      if (bus.ic_req_i || bus.dc_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.ic_req_i && bus.dc_req_i) m_win = m_prio;
        else m_win = bus.dc_req_i ? ARB_DC : ARB_IC;
        m_prio = (m_win == ARB_IC) ? ARB_DC : ARB_IC;
`else
        m_win = bus.dc_req_i ? ARB_DC : ARB_IC;
`endif
        m_active  = 1'b1;
        m_req_cyc = cyc + 1;
        m_rv_cyc  = -1;
        m_store   = (m_win == ARB_DC) && bus.dc_store_i;
        m_addr    = ((m_win == ARB_DC) ? bus.dc_addr_i : bus.ic_addr_i) / 16 * 16;
        m_wdata   = m_store ? bus.dc_wdata_i : 128'h0;
      end
    end else if (m_rv_cyc < 0 && cyc > m_req_cyc && bus.mem_resp_i) begin
      if (m_win == ARB_DC) m_dc_data = bus.mem_rdata_i;
      else m_ic_data = bus.mem_rdata_i;
      m_rv_cyc = cyc + 1;
    end else if (cyc == m_rv_cyc) begin
      m_active = 1'b0;
    end
  end

  initial begin
    int t0, rv;
    bit saw_rv;
    logic [127:0] wb;
    wb = 128'hDEADBEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    reset = 1'b1;
    bus.ic_req_i = 0; bus.ic_addr_i = '0;
    bus.dc_req_i = 0; bus.dc_store_i = 0; bus.dc_addr_i = '0; bus.dc_wdata_i = '0;
    bus.mem_resp_i = 0; bus.mem_rdata_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_ic_rdata", bus.ic_rdata_o, 128'h0);

    // lone icache fill
    tick(); t0 = cyc;
    bus.ic_req_i = 1; bus.ic_addr_i = 32'h0000_1004;
    wait_rv(1'b0, rv);
    tick(); bus.ic_req_i = 0;
    chk("ic_req_latency", obs_req_cyc - t0, 1);
    chk("ic_mem_addr", obs_addr, 32'h0000_1000);
    chk("ic_mem_store", obs_store, 1'b0);
    chk("ic_rv_latency", rv - t0, 12);
    chk("ic_fill_line", bus.ic_rdata_o, {4{32'hA5A5_1000}});

    // dcache write-back
    tick(); t0 = cyc;
    bus.dc_req_i = 1; bus.dc_store_i = 1; bus.dc_addr_i = 32'h0000_2010; bus.dc_wdata_i = wb;
    wait_rv(1'b1, rv);
    tick(); bus.dc_req_i = 0; bus.dc_store_i = 0;
    chk("wb_store", obs_store, 1'b1);
    chk("wb_addr", obs_addr, 32'h0000_2010);
    chk("wb_wdata", obs_wdata, wb);
    chk("wb_rv_latency", rv - t0, 12);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // simultaneous requests, dcache first
    tick(); t0 = cyc;
    bus.ic_req_i = 1; bus.ic_addr_i = 32'h0000_1100;
    bus.dc_req_i = 1; bus.dc_addr_i = 32'h0000_2200;
    wait_rv(1'b1, rv);
    chk("sim_dc_rv", rv - t0, 12);
    tick(); bus.dc_req_i = 0;
    wait_rv(1'b0, rv);
    chk("sim_ic_req", obs_req_cyc - t0, 14);
    chk("sim_ic_addr", obs_addr, 32'h0000_1100);
    chk("sim_ic_rv", rv - t0, 25);
    tick(); bus.ic_req_i = 0;
`else
    // continuous contention alternates starting from icache after reset
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    obs_addr_q.delete();
    bus.ic_req_i = 1; bus.ic_addr_i = 32'h0000_4000;
    bus.dc_req_i = 1; bus.dc_addr_i = 32'h0000_5000;
    for (int n = 0; n < 100 && obs_addr_q.size() < 4; n++) tick();
    bus.ic_req_i = 0; bus.dc_req_i = 0;
    repeat (15) tick();
    chk("rr_count", obs_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr_q.size(); i++)
      chk("rr_order", obs_addr_q[i], (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000);
`endif

    // reset while waiting, then a late response
    tick(); t0 = cyc;
    bus.ic_req_i = 1; bus.ic_addr_i = 32'h0000_7000;
    repeat (5) tick();
    reset = 1'b1; bus.ic_req_i = 0;
    tick(); reset = 1'b0;
    saw_rv = 1'b0;
    repeat (12) begin
      tick();
      if (bus.ic_rvalid_o || bus.dc_rvalid_o) saw_rv = 1'b1;
    end
    chk("rst_no_rvalid", saw_rv, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    tick(); t0 = cyc;
    bus.dc_req_i = 1; bus.dc_addr_i = 32'h0000_3000;
    wait_rv(1'b1, rv);
    tick(); bus.dc_req_i = 0;
    chk("post_rst_rv", rv - t0, 12);
    chk("post_rst_line", bus.dc_rdata_o, {4{32'hA5A5_3000}});

    // spurious response while idle
    spur = 1'b1;
    repeat (3) tick();
    chk("spur_dc_rdata", bus.dc_rdata_o, {4{32'hA5A5_3000}});
    chk("spur_ic_rdata", bus.ic_rdata_o, 128'h0);
    chk("spur_busy", bus.busy_o, 1'b0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
